// File: rtl/div_pkg.sv
// Shared types and constants for the multiply-add dividend reconstructor.
// Optional DIV_CHECK_EN flags inconsistent (R >= D) division triples.
package div_pkg;
    localparam int OPW       = 4;
    localparam int RESW      = 8;
    localparam int CNTW      = $clog2(OPW);
    localparam logic [RESW-1:0] DIV0_CODE = 8'hFF;
    localparam logic [7:0]      UIO_OE    = 8'b1110_0000;

    localparam int UIO_START = 4;
    localparam int UIO_BUSY  = 5;
    localparam int UIO_DONE  = 6;
    localparam int UIO_ERR   = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_ADD,
        ST_DONE
    } state_e;
endpackage

// File: rtl/mul4_shift_add.sv
// Serial 4x4 shift-add multiplier: one partial product per enabled step.
module mul4_shift_add
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clear,
    input  logic            step,
    input  logic [OPW-1:0]  q,
    input  logic [OPW-1:0]  d,
    output logic [RESW-1:0] acc,
    output logic [CNTW-1:0] cnt,
    output logic            last
);
    logic [RESW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (step) begin
            if (d[cnt_q])
                acc_d = acc_q + (RESW'(q) << cnt_q);
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (en) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc  = acc_q;
    assign cnt  = cnt_q;
    assign last = (cnt_q == CNTW'(OPW - 1));
endmodule

// File: rtl/tt_um_div_reconstruct.sv
// Rebuilds a dividend as Q*D + R over five cycles (4 multiply steps + add).
// Define DIV_CHECK_EN to raise err when the latched triple has R >= D.
module tt_um_div_reconstruct
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    state_e state_q, state_d;

    logic [OPW-1:0]  q_q, d_q, r_q;
    logic [RESW-1:0] res_q, res_d;
    logic [RESW-1:0] acc;
    logic [CNTW-1:0] cnt;
    logic            last;
    logic            start;
    logic            busy, done, err, clear, step, load;
    logic            unused_uio;

    assign start      = uio_in[UIO_START];
    assign unused_uio = &{1'b0, uio_in[7:5], cnt};

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else if (ena)
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_MUL;
            ST_MUL:  if (last)  state_d = ST_ADD;
            ST_ADD:             state_d = ST_DONE;
            ST_DONE:            state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE);
        clear = (state_q == ST_IDLE) && start;
        step  = (state_q == ST_MUL);
        load  = (state_q == ST_ADD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
            d_q <= '0;
            r_q <= '0;
        end else if (ena && clear) begin
            q_q <= ui_in[7:4];
            d_q <= ui_in[3:0];
            r_q <= uio_in[3:0];
        end
    end

    mul4_shift_add u_mul (
        .clk   (clk),
        .rst   (rst),
        .en    (ena),
        .clear (clear),
        .step  (step),
        .q     (q_q),
        .d     (d_q),
        .acc   (acc),
        .cnt   (cnt),
        .last  (last)
    );

    // A zero divisor reports the divider's div-by-zero code instead of Q*0+R.
    always_comb begin
        res_d = res_q;
        if (load)
            res_d = (d_q == '0) ? DIV0_CODE : acc + RESW'(r_q);
    end

    always_ff @(posedge clk) begin
        if (rst)
            res_q <= '0;
        else if (ena)
            res_q <= res_d;
    end

`ifdef DIV_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (load)
            err_d = (d_q != '0) && (r_q >= d_q);
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (ena)
            err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        uio_out            = '0;
        uio_out[UIO_BUSY]  = busy;
        uio_out[UIO_DONE]  = done;
        uio_out[UIO_ERR]   = err;
    end

    assign uo_out = res_q;
    assign uio_oe = UIO_OE;
endmodule

// File: tb/tb_tt_um_div_reconstruct.sv
// Randomized self-checking bench for tt_um_div_reconstruct against an arithmetic model.
module tb_tt_um_div_reconstruct;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    tt_um_div_reconstruct dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_res(input int q, input int d, input int r);
        if (d == 0) return 8'hFF;
        return 8'(q * d + r);
    endfunction

    function automatic logic ref_err(input int d, input int r);
`ifdef DIV_CHECK_EN
        return (d != 0) && (r >= d);
`else
        return 1'b0;
`endif
    endfunction

    // One operation; optional ena stall before enabled edge stall_at, optional
    // second start attempt at N+2, optional operand scrambling after the latch.
    task automatic run_op(input int q, input int d, input int r,
                          input int stall_at, input int stall_len,
                          input bit restart, input bit jitter);
        logic [7:0] prev;
        prev   = uo_out;
        ui_in  = {q[3:0], d[3:0]};
        uio_in = {3'b000, 1'b1, r[3:0]};
        ena    = 1'b1;
        tick();
        chk("busy_after_start", uio_out[5], 1'b1);
        chk("done_after_start", uio_out[6], 1'b0);
        uio_in[4] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (jitter) begin
                ui_in       = 8'($urandom);
                uio_in[3:0] = 4'($urandom);
            end
            if (restart && k == 2) begin
                ui_in     = 8'h11;
                uio_in[4] = 1'b1;
            end
            if (k == stall_at) begin
                ena = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    chk("stall_busy", uio_out[5], 1'b1);
                    chk("stall_done", uio_out[6], 1'b0);
                end
                ena = 1'b1;
            end
            tick();
            uio_in[4] = 1'b0;
            chk("busy_in_op", uio_out[5], 1'b1);
            if (k < 5) begin
                chk("done_early", uio_out[6], 1'b0);
                chk("result_held_in_op", uo_out, prev);
            end else begin
                chk("done_pulse", uio_out[6], 1'b1);
                chk("result", uo_out, ref_res(q, d, r));
                chk("err", uio_out[7], ref_err(d, r));
            end
        end
        tick();
        chk("done_single", uio_out[6], 1'b0);
        chk("busy_idle", uio_out[5], 1'b0);
        chk("result_hold", uo_out, ref_res(q, d, r));
        chk("err_hold", uio_out[7], ref_err(d, r));
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        tick();
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'hE0);
        rst = 1'b0;
        ena = 1'b1;
        tick();

        run_op(2, 3, 1, 0, 0, 1'b0, 1'b0);
        run_op(15, 15, 15, 0, 0, 1'b0, 1'b0);
        run_op(11, 0, 9, 0, 0, 1'b0, 1'b1);
        run_op(5, 4, 3, 0, 0, 1'b1, 1'b0);
        run_op(9, 7, 2, 2, 3, 1'b0, 1'b0);

        // start held high through DONE: new op only one edge after IDLE
        ui_in  = 8'h34;
        uio_in = 8'h12;
        tick();
        for (int k = 1; k <= 5; k++) tick();
        chk("held_done", uio_out[6], 1'b1);
        chk("held_result", uo_out, ref_res(3, 4, 2));
        tick();
        chk("held_idle_busy", uio_out[5], 1'b0);
        tick();
        chk("held_restart_busy", uio_out[5], 1'b1);
        uio_in[4] = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        chk("held_second_done", uio_out[6], 1'b1);
        tick();

        // reset mid-operation, asserted while ena is low
        ui_in  = 8'h66;
        uio_in = 8'h10;
        tick();
        uio_in = 8'h00;
        tick();
        tick();
        rst = 1'b1;
        ena = 1'b0;
        tick();
        chk("abort_uo_out", uo_out, 8'h00);
        chk("abort_uio_out", uio_out, 8'h00);
        rst = 1'b0;
        ena = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_done", uio_out[6], 1'b0);
        end
        run_op(1, 2, 1, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            int q, d, r, sa, sl, gap;
            logic [7:0] held;
            q   = $urandom_range(15);
            d   = $urandom_range(15);
            r   = $urandom_range(15);
            sa  = $urandom_range(5);
            sl  = $urandom_range(1, 4);
            gap = $urandom_range(3);
            run_op(q, d, r, sa, sl, 1'($urandom_range(1)), 1'b1);
            held = ref_res(q, d, r);
            uio_in[4] = 1'b0;
            for (int g = 0; g < gap; g++) begin
                ena = 1'($urandom_range(1));
                tick();
                chk("gap_hold", uo_out, held);
                chk("gap_busy", uio_out[5], 1'b0);
            end
            ena = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck expected finish");
        $fatal(1);
    end
endmodule
